// File: rtl/dmem_write_buffer.sv
// Data-memory store buffer: a FIFO of pending stores that drains into Data_Memory
// whenever the CPU is not loading, with store-to-load forwarding from the youngest match.
module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [63:0] cpu_address,
    input  logic [63:0] cpu_data_in,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    output logic [63:0] cpu_data_out,
    output logic        cpu_stall,
    output logic [63:0] mem_address,
    output logic [63:0] mem_data_in,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [63:0] mem_data_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [63:0]      r_addr [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_load;
    logic             w_enqueue;
    logic             w_drain;
    logic             w_hit;
    logic [63:0]      w_hitData;
    logic [PTR_W-1:0] w_idx;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign cpu_stall = cpu_memwrite & w_full;
    // A store wins over a simultaneous load, and any asserted read request holds off draining.
    assign w_load    = cpu_memread & ~cpu_memwrite;
    assign w_enqueue = cpu_memwrite & ~w_full;
    assign w_drain   = ~w_empty & ~cpu_memread;

    // Walk entries oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit     = 1'b0;
        w_hitData = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == cpu_address)) begin
                w_hit     = 1'b1;
                w_hitData = r_data[w_idx];
            end
        end
    end

    always_comb begin
        cpu_data_out = '0;
        mem_address  = '0;
        mem_data_in  = '0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        if (w_load) begin
            if (w_hit) begin
                cpu_data_out = w_hitData;
            end else begin
                mem_memread  = 1'b1;
                mem_address  = cpu_address;
                cpu_data_out = mem_data_out;
            end
        end else if (w_drain) begin
            mem_memwrite = 1'b1;
            mem_address  = r_addr[r_rdPtr];
            mem_data_in  = r_data[r_rdPtr];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enqueue) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_drain) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_enqueue, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: the count alone decides which entries are valid.
    always_ff @(posedge CLOCK) begin
        if (w_enqueue && !RESET) begin
            r_addr[r_wrPtr] <= cpu_address;
            r_data[r_wrPtr] <= cpu_data_in;
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed vector table, a full-buffer sequence,
// then random traffic checked against a queue-based store-buffer model.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam logic [63:0] INIT = 64'hC0DE_0000_0000_0000;

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [63:0] addr;
        logic [63:0] data;
        logic        eStall;
        logic        eWr;
        logic        eRd;
        logic [63:0] eMemAddr;
        logic [63:0] eMemData;
        logic [63:0] eOut;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [63:0] cpu_address;
    logic [63:0] cpu_data_in;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [63:0] cpu_data_out;
    logic        cpu_stall;
    logic [63:0] mem_address;
    logic [63:0] mem_data_in;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [63:0] mem_data_out;

    logic        memInit;
    logic [63:0] memArr [256];
    logic [63:0] refMem [256];
    ent_t        modelQ [$];
    vec_t        vecs [$];
    vec_t        seq [$];
    int          testCount = 0;
    int          failCount = 0;

    dmem_write_buffer #(.DEPTH(DEPTH)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .cpu_address  (cpu_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_data_out (cpu_data_out),
        .cpu_stall    (cpu_stall),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .mem_data_out (mem_data_out)
    );

    always #5 CLOCK = ~CLOCK;

    // Data_Memory stand-in: combinational read, write on the rising edge.
    assign mem_data_out = memArr[mem_address[7:0]];

    always @(posedge CLOCK) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) memArr[i] <= INIT | 64'(i);
        end else if (mem_memwrite) begin
            memArr[mem_address[7:0]] <= mem_data_in;
        end
    end

    function automatic vec_t mk(input logic rst, input logic we, input logic re,
                                input logic [63:0] addr, input logic [63:0] data,
                                input logic eStall, input logic eWr, input logic eRd,
                                input logic [63:0] eMemAddr, input logic [63:0] eMemData,
                                input logic [63:0] eOut);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.data = data;
        v.eStall = eStall; v.eWr = eWr; v.eRd = eRd;
        v.eMemAddr = eMemAddr; v.eMemData = eMemData; v.eOut = eOut;
        return v;
    endfunction

    // Inputs change on the falling edge, far from the rising edge the DUT uses.
    task automatic applyStimulus(input logic rst, input logic we, input logic re,
                                 input logic [63:0] addr, input logic [63:0] data);
        @(negedge CLOCK);
        RESET        = rst;
        cpu_memwrite = we;
        cpu_memread  = re;
        cpu_address  = addr;
        cpu_data_in  = data;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eStall, input logic eWr, input logic eRd,
                            input logic [63:0] eMemAddr, input logic [63:0] eMemData,
                            input logic [63:0] eOut);
        checkOutput({tag, ".stall"}, 64'(cpu_stall), 64'(eStall));
        checkOutput({tag, ".strobes"}, 64'({mem_memwrite, mem_memread}), 64'({eWr, eRd}));
        checkOutput({tag, ".memAddr"}, mem_address, eMemAddr);
        checkOutput({tag, ".memData"}, mem_data_in, eMemData);
        checkOutput({tag, ".cpuOut"}, cpu_data_out, eOut);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v.rst, v.we, v.re, v.addr, v.data);
        checkAll(tag, v.eStall, v.eWr, v.eRd, v.eMemAddr, v.eMemData, v.eOut);
    endtask

    // Reference model: pending stores as a queue, memory as a plain array.
    task automatic runModelCycle(input logic rst, input logic we, input logic re,
                                 input logic [63:0] addr, input logic [63:0] data, input int n);
        logic        eStall, eWr, eRd, hit;
        logic [63:0] eA, eD, eO;
        ent_t        e;
        applyStimulus(rst, we, re, addr, data);
        eStall = we && (modelQ.size() == DEPTH);
        eWr = 1'b0; eRd = 1'b0; eA = '0; eD = '0; eO = '0; hit = 1'b0;
        if (re && !we) begin
            foreach (modelQ[k]) begin
                if (modelQ[k].a == addr) begin
                    hit = 1'b1;
                    eO  = modelQ[k].d;
                end
            end
            if (!hit) begin
                eRd = 1'b1;
                eA  = addr;
                eO  = refMem[addr[7:0]];
            end
        end else if (!re && modelQ.size() > 0) begin
            eWr = 1'b1;
            eA  = modelQ[0].a;
            eD  = modelQ[0].d;
        end
        checkAll($sformatf("rand%0d", n), eStall, eWr, eRd, eA, eD, eO);
        if (eWr) begin
            refMem[eA[7:0]] = eD;
            void'(modelQ.pop_front());
        end
        if (rst) begin
            modelQ.delete();
        end else if (we && !eStall) begin
            e.a = addr;
            e.d = data;
            modelQ.push_back(e);
        end
    endtask

    initial begin
        RESET = 1'b1; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
        cpu_address = '0; cpu_data_in = '0; memInit = 1'b1;
        repeat (2) @(negedge CLOCK);
        memInit = 1'b0;

        // Directed vectors, starting from reset with memory at its initial pattern.
        vecs.push_back(mk(0,0,0, 0, 0,          0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,1,0, 'h10, 'hAA,    0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,1,0, 'h10, 'hAA, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,1, 'h10, 0,       0,0,1, 'h10, 0, 'hAA));
        vecs.push_back(mk(0,1,1, 'h20, 1,       0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,1,1, 'h20, 2,       0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,1, 'h20, 0,       0,0,0, 0, 0, 2));
        vecs.push_back(mk(0,0,1, 'h40, 0,       0,0,1, 'h40, 0, INIT | 64'h40));
        vecs.push_back(mk(0,0,0, 0, 0,          0,1,0, 'h20, 1, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,1,0, 'h20, 2, 0));
        vecs.push_back(mk(0,0,1, 'h20, 0,       0,0,1, 'h20, 0, 2));
        vecs.push_back(mk(0,1,1, 'h30, 'h11,    0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,1,1, 'h31, 'h22,    0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,1,1, 'h32, 'h33,    0,0,0, 0, 0, 0));
        vecs.push_back(mk(1,1,0, 'h33, 'h44,    0,1,0, 'h30, 'h11, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,1, 'h31, 0,       0,0,1, 'h31, 0, INIT | 64'h31));
        vecs.push_back(mk(0,0,1, 'h33, 0,       0,0,1, 'h33, 0, INIT | 64'h33));
        vecs.push_back(mk(0,0,1, 'h30, 0,       0,0,1, 'h30, 0, 'h11));
        vecs.push_back(mk(0,1,1, 64'h1_0000_0010, 'hBB, 0,0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,1, 'h10, 0,       0,0,1, 'h10, 0, 'hAA));
        vecs.push_back(mk(0,0,1, 64'h1_0000_0010, 0, 0,0,0, 0, 0, 'hBB));
        vecs.push_back(mk(0,0,0, 0, 0,          0,1,0, 64'h1_0000_0010, 'hBB, 0));
        vecs.push_back(mk(0,0,0, 0, 0,          0,0,0, 0, 0, 0));
        foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

        // Fill the buffer while loads hold drain off, then let it drain in order.
        for (int k = 0; k < DEPTH; k++)
            seq.push_back(mk(0,1,1, 64'h50 + 64'(k), 64'h500 + 64'(k), 0,0,0, 0, 0, 0));
        seq.push_back(mk(0,1,1, 'h54, 'h504,    1,0,0, 0, 0, 0));
        seq.push_back(mk(0,1,0, 'h54, 'h504,    1,1,0, 'h50, 'h500, 0));
        seq.push_back(mk(0,1,0, 'h54, 'h504,    0,1,0, 'h51, 'h501, 0));
        for (int k = 2; k <= DEPTH; k++)
            seq.push_back(mk(0,0,0, 0, 0, 0,1,0, 64'h50 + 64'(k), 64'h500 + 64'(k), 0));
        seq.push_back(mk(0,0,0, 0, 0,           0,0,0, 0, 0, 0));
        foreach (seq[i]) runVector(seq[i], $sformatf("full%0d", i));

        // Random traffic from a clean reset with freshly initialised memory.
        @(negedge CLOCK);
        RESET = 1'b1; cpu_memwrite = 1'b0; cpu_memread = 1'b0; memInit = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0; memInit = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = INIT | 64'(i);
        modelQ.delete();
        for (int n = 0; n < 2000; n++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 1) == 1) ? 64'h8000_0000_0000_0000 : 64'h0;
            a = a | 64'($urandom_range(0, 7));
            runModelCycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, a, {$urandom, $urandom}, n);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
